// File: rtl/silu_pwl_table_loader_pkg.sv
// silu_pwl_pkg: widths, error codes and loader states shared by
// the SiLU PWL table loader, its table bank and its config interface.
package silu_pwl_pkg;

    localparam int DATA_W   = 16;
    localparam int FRAC_W   = 9;
    localparam int NSEG_MAX = 66;
    localparam int IDX_W    = 7;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BAD_COUNT = 2'd1,
        ERR_LENGTH    = 2'd2,
        ERR_ORDER     = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BP,
        ST_BIAS,
        ST_COMMIT,
        ST_DRAIN
    } ld_state_e;

endpackage

// File: rtl/silu_pwl_table_loader_if.sv
// Config stream handshake: cfg_valid/cfg_ready with data and frame end.
// master drives valid/data/last, slave (the loader) drives ready.
interface silu_pwl_table_loader_if;
    import silu_pwl_pkg::*;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_last;

    modport master (
        output cfg_valid,
        output cfg_data,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  cfg_last,
        output cfg_ready
    );

endinterface

// File: rtl/silu_pwl_table_loader_bank.sv
// pwl_table_bank: two banks of (bp, bias) entries. Writes go to the
// shadow bank (~bank_sel); registered reads come from the active bank.
// Ports: clk, rst, bank_sel, we_bp/we_bias/wr_idx/wr_data (write),
// rd_idx/rd_zero (lookup, rd_zero forces 0), rd_bp/rd_bias (1-cycle).
module pwl_table_bank
    import silu_pwl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bank_sel,
    input  logic              we_bp,
    input  logic              we_bias,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic              rd_zero,
    output logic [DATA_W-1:0] rd_bp,
    output logic [DATA_W-1:0] rd_bias
);

    logic [DATA_W-1:0] bp_mem   [2][NSEG_MAX];
    logic [DATA_W-1:0] bias_mem [2][NSEG_MAX];
    logic              shadow;

    assign shadow = ~bank_sel;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_bp)
            bp_mem[shadow][wr_idx] <= wr_data;
        if (we_bias)
            bias_mem[shadow][wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bp   <= '0;
            rd_bias <= '0;
        end else if (rd_zero) begin
            rd_bp   <= '0;
            rd_bias <= '0;
        end else begin
            rd_bp   <= bp_mem[bank_sel][rd_idx];
            rd_bias <= bias_mem[bank_sel][rd_idx];
        end
    end

endmodule

// File: rtl/silu_pwl_table_loader.sv
// silu_pwl_table_loader: checks a framed (N, bp/bias pairs) stream,
// fills the shadow bank and swaps it live on a clean frame.
// Ports: clk, rst, cfg (slave handshake), rd_idx -> rd_bp/rd_bias,
// seg_count, table_ok, load_done/load_err pulses, err_code.
module silu_pwl_table_loader
    import silu_pwl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    silu_pwl_table_loader_if.slave cfg,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_bp,
    output logic [DATA_W-1:0] rd_bias,
    output logic [IDX_W-1:0]  seg_count,
    output logic              table_ok,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code
);

    ld_state_e         state, state_nx;
    err_code_e         err_q, err_nx;
    logic              err_hit;
    logic [IDX_W-1:0]  k, n;
    logic [IDX_W-1:0]  hdr_n;
    logic [DATA_W-1:0] prev_bp;
    logic              bank_sel;
    logic              acc, hdr_bad, last_pair, ord_bad;
    logic              we_bp, we_bias, rd_zero;

    assign acc       = cfg.cfg_valid & cfg.cfg_ready;
    assign hdr_n     = cfg.cfg_data[IDX_W-1:0];
    assign hdr_bad   = (cfg.cfg_data[DATA_W-1:IDX_W] != '0)
                     || (hdr_n == '0)
                     || (hdr_n > IDX_W'(NSEG_MAX));
    assign last_pair = (k == n - IDX_W'(1));
    assign ord_bad   = (k != '0)
                     && ($signed(cfg.cfg_data) <= $signed(prev_bp));
    assign rd_zero   = !table_ok || (rd_idx >= seg_count);
    assign err_code  = err_q;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // An error on a word that also carries cfg_last ends the
    // frame right there, so DRAIN is skipped.
    always_comb begin
        state_nx = state;
        err_nx   = ERR_NONE;
        err_hit  = 1'b0;
        unique case (state)
            ST_IDLE: if (acc) begin
                if (hdr_bad) begin
                    err_hit  = 1'b1;
                    err_nx   = ERR_BAD_COUNT;
                    state_nx = cfg.cfg_last ? ST_IDLE : ST_DRAIN;
                end else if (cfg.cfg_last) begin
                    err_hit  = 1'b1;
                    err_nx   = ERR_LENGTH;
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_BP;
                end
            end
            ST_BP: if (acc) begin
                if (cfg.cfg_last) begin
                    err_hit  = 1'b1;
                    err_nx   = ERR_LENGTH;
                    state_nx = ST_IDLE;
                end else if (ord_bad) begin
                    err_hit  = 1'b1;
                    err_nx   = ERR_ORDER;
                    state_nx = ST_DRAIN;
                end else begin
                    state_nx = ST_BIAS;
                end
            end
            ST_BIAS: if (acc) begin
                if (last_pair && cfg.cfg_last) begin
                    state_nx = ST_COMMIT;
                end else if (last_pair || cfg.cfg_last) begin
                    err_hit  = 1'b1;
                    err_nx   = ERR_LENGTH;
                    state_nx = cfg.cfg_last ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_nx = ST_BP;
                end
            end
            ST_COMMIT: state_nx = ST_IDLE;
            ST_DRAIN: if (acc && cfg.cfg_last)
                state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Ready is high in BP/BIAS, so valid alone qualifies writes.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        load_done     = 1'b0;
        we_bp         = 1'b0;
        we_bias       = 1'b0;
        unique case (1'b1)
            state == ST_COMMIT: begin
                cfg.cfg_ready = 1'b0;
                load_done     = 1'b1;
            end
            state == ST_BP:   we_bp   = cfg.cfg_valid;
            state == ST_BIAS: we_bias = cfg.cfg_valid;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            n         <= '0;
            prev_bp   <= '0;
            err_q     <= ERR_NONE;
            load_err  <= 1'b0;
            bank_sel  <= 1'b0;
            seg_count <= '0;
            table_ok  <= 1'b0;
        end else begin
            load_err <= (err_hit && cfg.cfg_last)
                     || (state == ST_DRAIN && acc && cfg.cfg_last);
            if (state == ST_IDLE && acc) begin
                err_q <= ERR_NONE;
                n     <= hdr_n;
                k     <= '0;
            end
            if (err_hit)
                err_q <= err_nx;
            if (we_bp)
                prev_bp <= cfg.cfg_data;
            if (we_bias && !last_pair)
                k <= k + IDX_W'(1);
            if (state == ST_COMMIT) begin
                bank_sel  <= ~bank_sel;
                seg_count <= n;
                table_ok  <= 1'b1;
            end
        end
    end

    pwl_table_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .bank_sel(bank_sel),
        .we_bp   (we_bp),
        .we_bias (we_bias),
        .wr_idx  (k),
        .wr_data (cfg.cfg_data),
        .rd_idx  (rd_idx),
        .rd_zero (rd_zero),
        .rd_bp   (rd_bp),
        .rd_bias (rd_bias)
    );

endmodule

// File: tb/tb_silu_pwl_table_loader.sv
// Bench for silu_pwl_table_loader: vector table, hand sequences
// and random frames judged by a frame-level reference model.
module tb_silu_pwl_table_loader;
    import silu_pwl_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_bp, rd_bias;
    logic [IDX_W-1:0]  seg_count;
    logic              table_ok, load_done, load_err;
    logic [1:0]        err_code;

    silu_pwl_table_loader_if cfg_bus();

    silu_pwl_table_loader dut (
        .clk      (clk),
        .rst      (rst),
        .cfg      (cfg_bus),
        .rd_idx   (rd_idx),
        .rd_bp    (rd_bp),
        .rd_bias  (rd_bias),
        .seg_count(seg_count),
        .table_ok (table_ok),
        .load_done(load_done),
        .load_err (load_err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] fw[$];
    logic [15:0] m_bp   [NSEG_MAX];
    logic [15:0] m_bias [NSEG_MAX];
    int          m_n  = 0;
    bit          m_ok = 1'b0;

    typedef struct {
        string       name;
        logic [15:0] hdr;
        int          len;
        int          brk;
        int          code;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Holds the word until an edge where ready was high.
    task automatic send_word(input logic [15:0] d, input logic l);
        int   t;
        logic r;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_data  = d;
        cfg_bus.cfg_last  = l;
        t = 0;
        do begin
            r = cfg_bus.cfg_ready;
            step();
            t++;
        end while (!r && t < 20);
        if (!r) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: ready %0b want 1", r);
        end
    endtask

    // Frame-level rules: a good frame has 2N+1 words and strictly
    // rising bps; otherwise the earliest detectable fault wins.
    function automatic int judge(input logic [15:0] w[$]);
        int n, L, len_pos, ord_pos, NONE;
        NONE = 1 << 30;
        L = w.size();
        n = int'(w[0][6:0]);
        if (w[0][15:7] != 9'd0 || n == 0 || n > NSEG_MAX)
            return 1;
        if (L == 2 * n + 1)
            len_pos = NONE;
        else
            len_pos = (L - 1 < 2 * n) ? L - 1 : 2 * n;
        ord_pos = NONE;
        for (int i = 1; i < n; i++) begin
            if (2 * i + 1 > L - 1)
                break;
            if ($signed(w[2*i+1]) <= $signed(w[2*i-1])) begin
                ord_pos = 2 * i + 1;
                break;
            end
        end
        if (len_pos == NONE && ord_pos == NONE)
            return 0;
        if (ord_pos < len_pos)
            return 3;
        return 2;
    endfunction

    function automatic logic [15:0] exp_bp(input int i);
        return (m_ok && i < m_n) ? m_bp[i] : 16'h0;
    endfunction

    function automatic logic [15:0] exp_bias(input int i);
        return (m_ok && i < m_n) ? m_bias[i] : 16'h0;
    endfunction

    task automatic commit_model();
        m_n = int'(fw[0][6:0]);
        for (int i = 0; i < m_n; i++) begin
            m_bp[i]   = fw[1+2*i];
            m_bias[i] = fw[2+2*i];
        end
        m_ok = 1'b1;
    endtask

    task automatic rd_chk(input string nm, input int i);
        rd_idx = IDX_W'(i);
        step();
        chk({nm, "_rd_bp"}, rd_bp, exp_bp(i));
        chk({nm, "_rd_bias"}, rd_bias, exp_bias(i));
    endtask

    task automatic run_frame(input string nm, input int code);
        for (int i = 0; i < fw.size(); i++)
            send_word(fw[i], i == fw.size() - 1);
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_last  = 1'b0;
        chk({nm, "_done"}, load_done, code == 0);
        chk({nm, "_err"}, load_err, code != 0);
        chk({nm, "_code"}, err_code, code);
        if (code == 0)
            commit_model();
        step();
        chk({nm, "_pulse_clr"}, {load_done, load_err}, 0);
        chk({nm, "_seg"}, seg_count, m_n);
        chk({nm, "_ok"}, table_ok, m_ok);
        rd_chk(nm, (m_n > 0) ? int'($urandom_range(0, m_n - 1)) : 0);
        rd_chk(nm, int'($urandom_range(0, 127)));
    endtask

    task automatic build_tab(input logic [15:0] hdr, input int len,
                             input int brk);
        int j, jj;
        fw.delete();
        fw.push_back(hdr);
        for (int idx = 1; idx < len; idx++) begin
            j = (idx - 1) / 2;
            if (idx % 2 == 1) begin
                jj = (brk > 0 && j == brk) ? j - 1 : j;
                fw.push_back(16'hF000 + 16'(jj * 256));
            end else begin
                fw.push_back(16'h0010 + 16'(j * 3));
            end
        end
    endtask

    initial begin
        logic [15:0] hdr, old_bp;
        int n, L, brk, bp, code;

        vecs[0]  = '{"n2_ok",       16'h0002,   5, 0, 0};
        vecs[1]  = '{"n67_bad",     16'h0043, 135, 0, 1};
        vecs[2]  = '{"n3_order",    16'h0003,   7, 2, 3};
        vecs[3]  = '{"n2_short",    16'h0002,   3, 0, 2};
        vecs[4]  = '{"n0_last",     16'h0000,   1, 0, 1};
        vecs[5]  = '{"n0_drain",    16'h0000,   4, 0, 1};
        vecs[6]  = '{"upper_bits",  16'h0081,   3, 0, 1};
        vecs[7]  = '{"hdr_last",    16'h0005,   1, 0, 2};
        vecs[8]  = '{"n2_long",     16'h0002,   7, 0, 2};
        vecs[9]  = '{"n66_ok",      16'h0042, 133, 0, 0};
        vecs[10] = '{"n1_ok",       16'h0001,   3, 0, 0};
        vecs[11] = '{"last_on_bp",  16'h0002,   4, 0, 2};
        vecs[12] = '{"order_early", 16'h0004,  12, 1, 3};

        rst = 1'b1;
        rd_idx = '0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_data  = '0;
        cfg_bus.cfg_last  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_ready", cfg_bus.cfg_ready, 1);
        chk("rst_seg", seg_count, 0);
        chk("rst_ok", table_ok, 0);
        chk("rst_pulses", {load_done, load_err}, 0);
        chk("rst_code", err_code, 0);
        chk("rst_rd", {rd_bp, rd_bias}, 0);
        rd_chk("empty", 0);

        fw = '{16'h0002, 16'hF000, 16'h0000, 16'h0000, 16'hFFF9};
        run_frame("spec_n2", 0);
        rd_idx = 7'd1;
        step();
        chk("spec_rd1_bp", rd_bp, 16'h0000);
        chk("spec_rd1_bias", rd_bias, 16'hFFF9);
        rd_idx = 7'd2;
        step();
        chk("spec_rd2", {rd_bp, rd_bias}, 0);

        fw = '{16'h0001, 16'h0100, 16'h0011};
        for (int i = 0; i < 3; i++)
            send_word(fw[i], i == 2);
        chk("b2b_ready_commit", cfg_bus.cfg_ready, 0);
        chk("b2b_done1", load_done, 1);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_data  = 16'h0001;
        cfg_bus.cfg_last  = 1'b0;
        rd_idx = '0;
        old_bp = exp_bp(0);
        step();
        chk("b2b_rd_old", rd_bp, old_bp);
        chk("b2b_ready_idle", cfg_bus.cfg_ready, 1);
        commit_model();
        step();
        chk("b2b_rd_new", rd_bp, 16'h0100);
        fw = '{16'h0001, 16'h0200, 16'h0022};
        send_word(16'h0200, 1'b0);
        send_word(16'h0022, 1'b1);
        chk("b2b_done2", load_done, 1);
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_last  = 1'b0;
        commit_model();
        step();
        chk("b2b_seg", seg_count, 1);
        rd_chk("b2b_f2", 0);

        foreach (vecs[v]) begin
            build_tab(vecs[v].hdr, vecs[v].len, vecs[v].brk);
            run_frame(vecs[v].name, vecs[v].code);
        end

        for (int f = 0; f < 40; f++) begin
            fw.delete();
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0: hdr = 16'h0000;
                    1: hdr = 16'($urandom_range(67, 127));
                    default: hdr = {9'($urandom_range(1, 511)),
                                    7'($urandom_range(1, 66))};
                endcase
                n = 3;
                L = int'($urandom_range(1, 6));
            end else begin
                n = int'($urandom_range(1, 66));
                hdr = 16'(n);
                if ($urandom_range(0, 3) == 0)
                    L = int'($urandom_range(1, 2 * n + 4));
                else
                    L = 2 * n + 1;
            end
            fw.push_back(hdr);
            bp = -int'($urandom_range(4000, 8000));
            brk = (n > 1 && $urandom_range(0, 3) == 0)
                ? int'($urandom_range(1, n - 1)) : 0;
            for (int i = 1; i < L; i++) begin
                if (i % 2 == 1) begin
                    if (i > 1) begin
                        if ((i - 1) / 2 == brk)
                            bp = bp - int'($urandom_range(0, 3));
                        else
                            bp = bp + int'($urandom_range(1, 200));
                    end
                    fw.push_back(16'(bp));
                end else begin
                    fw.push_back(16'($urandom));
                end
            end
            code = judge(fw);
            run_frame("rand", code);
        end

        fw = '{16'h0001, 16'h0040, 16'h0041};
        run_frame("pre_rst", 0);
        send_word(16'h0003, 1'b0);
        send_word(16'h0010, 1'b0);
        send_word(16'h0020, 1'b0);
        cfg_bus.cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ok = 1'b0;
        m_n  = 0;
        chk("mid_rst_ok", table_ok, 0);
        chk("mid_rst_seg", seg_count, 0);
        chk("mid_rst_rd", {rd_bp, rd_bias}, 0);
        chk("mid_rst_pulses", {load_done, load_err}, 0);
        chk("mid_rst_code", err_code, 0);
        step();
        chk("mid_rst_pulses2", {load_done, load_err}, 0);
        rd_chk("mid_rst", 0);
        fw = '{16'h0001, 16'h0050, 16'h0051};
        run_frame("post_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
